// File: rtl/sleep_pkg.sv
// sleep_pkg: shared state encodings and default tick constants for the sleep controller.
package sleep_pkg;
  typedef enum logic [1:0] {
    ST_AWAKE  = 2'd0,
    ST_DROWSY = 2'd1,
    ST_ASLEEP = 2'd2,
    ST_WAKING = 2'd3
  } state_t;
  localparam int DEF_CNT_W            = 8;
  localparam int DEF_DROWSY_TICKS     = 4;
  localparam int DEF_DEEP_AFTER_TICKS = 8;
  localparam int DEF_MIN_SLEEP_TICKS  = 16;
  localparam int DEF_WAKING_TICKS     = 2;
endpackage

// File: rtl/sleep_cycle_controller_if.sv
// sleep_cycle_controller_if: request inputs and sleep status outputs of the controller.
interface sleep_cycle_controller_if
  import sleep_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             tick;
  logic             sleep_in_signal;
  logic             wake_up_signal;
  logic             vital_energy_zero;
  logic             urgent_wake;
  state_t           state;
  logic             is_asleep;
  logic             is_drowsy;
  logic             deep_sleep;
  logic             restore_pulse;
  logic [CNT_W-1:0] last_sleep_ticks;
  modport master (
    output tick, sleep_in_signal, wake_up_signal, vital_energy_zero, urgent_wake,
    input  state, is_asleep, is_drowsy, deep_sleep, restore_pulse, last_sleep_ticks
  );
  modport slave (
    input  tick, sleep_in_signal, wake_up_signal, vital_energy_zero, urgent_wake,
    output state, is_asleep, is_drowsy, deep_sleep, restore_pulse, last_sleep_ticks
  );
endinterface

// File: rtl/sleep_tick_counter.sv
// sleep_tick_counter: saturating in-state tick counter with clear and enable.
module sleep_tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (en && ~&q) q <= q + 1'b1;
endmodule

// File: rtl/sleep_cycle_controller.sv
// sleep_cycle_controller: tick-paced AWAKE/DROWSY/ASLEEP/WAKING sequencer with sleep-depth tracking.
module sleep_cycle_controller
  import sleep_pkg::*;
#(
  parameter int CNT_W            = DEF_CNT_W,
  parameter int DROWSY_TICKS     = DEF_DROWSY_TICKS,
  parameter int DEEP_AFTER_TICKS = DEF_DEEP_AFTER_TICKS,
  parameter int MIN_SLEEP_TICKS  = DEF_MIN_SLEEP_TICKS,
  parameter int WAKING_TICKS     = DEF_WAKING_TICKS
) (
  input logic clk,
  input logic rst,
  sleep_cycle_controller_if.slave bus
);
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, last;
  logic             chg, deep, pulse;
  assign chg  = nxt != state;
  assign deep = state == ST_ASLEEP && cnt >= CNT_W'(DEEP_AFTER_TICKS);
  sleep_tick_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(chg),
    .en (bus.tick),
    .q  (cnt)
  );
  // Collapse outranks sleep_in; urgent and normal wake merge into one WAKING entry.
  always_comb begin
    nxt = state;
    if (bus.tick)
      case (state)
        ST_AWAKE:  nxt = bus.vital_energy_zero ? ST_ASLEEP : bus.sleep_in_signal ? ST_DROWSY : ST_AWAKE;
        ST_DROWSY: nxt = bus.vital_energy_zero ? ST_ASLEEP : !bus.sleep_in_signal ? ST_AWAKE :
                         cnt == CNT_W'(DROWSY_TICKS - 1) ? ST_ASLEEP : ST_DROWSY;
        ST_ASLEEP: nxt = (bus.urgent_wake || (bus.wake_up_signal && cnt >= CNT_W'(MIN_SLEEP_TICKS))) ?
                         ST_WAKING : ST_ASLEEP;
        ST_WAKING: nxt = cnt == CNT_W'(WAKING_TICKS - 1) ? ST_AWAKE : ST_WAKING;
        default:   nxt = ST_AWAKE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_AWAKE;
      last  <= '0;
      pulse <= 1'b0;
    end else begin
      state <= nxt;
      pulse <= bus.tick && deep;
      if (chg && state == ST_ASLEEP) last <= ~&cnt ? cnt + 1'b1 : cnt;
    end
  assign bus.state            = state;
  assign bus.is_asleep        = state == ST_ASLEEP || state == ST_WAKING;
  assign bus.is_drowsy        = state == ST_DROWSY;
  assign bus.deep_sleep       = deep;
  assign bus.restore_pulse    = pulse;
  assign bus.last_sleep_ticks = last;
endmodule

// File: tb/tb_sleep_cycle_controller.sv
// tb_sleep_cycle_controller: directed and random stimulus checked against a behavioural sleep model.
module tb_sleep_cycle_controller;
  import sleep_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  sleep_cycle_controller_if #(.CNT_W(8)) bus ();
  sleep_cycle_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // Model: mode number, unbounded ticks spent in the mode, last reported sleep length.
  int m_state, m_n, m_last, m_ns;
  bit m_pulse;

  function automatic int next_mode(int s, int n, bit si, bit w, bit v, bit u);
    if (s == 0) return v ? 2 : si ? 1 : 0;
    if (s == 1) return v ? 2 : !si ? 0 : (n + 1 >= DEF_DROWSY_TICKS) ? 2 : 1;
    if (s == 2) return (u || (w && n >= DEF_MIN_SLEEP_TICKS)) ? 3 : 2;
    return (n + 1 >= DEF_WAKING_TICKS) ? 0 : 3;
  endfunction

  always_comb m_ns = next_mode(m_state, m_n, bus.sleep_in_signal, bus.wake_up_signal,
                               bus.vital_energy_zero, bus.urgent_wake);

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_state <= 0;
      m_n     <= 0;
      m_last  <= 0;
      m_pulse <= 1'b0;
    end else begin
      m_pulse <= bus.tick && m_state == 2 && m_n >= DEF_DEEP_AFTER_TICKS;
      if (bus.tick) begin
        m_state <= m_ns;
        m_n     <= (m_ns != m_state) ? 0 : m_n + 1;
        if (m_ns != m_state && m_state == 2) m_last <= (m_n + 1 > 255) ? 255 : m_n + 1;
      end
    end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.restore_pulse) pulses++;
    if (!rst) begin
      chk("state", int'(bus.state), m_state);
      chk("is_asleep", int'(bus.is_asleep), int'(m_state >= 2));
      chk("is_drowsy", int'(bus.is_drowsy), int'(m_state == 1));
      chk("deep_sleep", int'(bus.deep_sleep), int'(m_state == 2 && m_n >= DEF_DEEP_AFTER_TICKS));
      chk("restore_pulse", int'(bus.restore_pulse), int'(m_pulse));
      chk("last_sleep_ticks", int'(bus.last_sleep_ticks), m_last);
    end
  end

  task automatic cyc(input bit t, input bit si, input bit w, input bit v, input bit u);
    bus.tick              = t;
    bus.sleep_in_signal   = si;
    bus.wake_up_signal    = w;
    bus.vital_energy_zero = v;
    bus.urgent_wake       = u;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic fall_asleep();
    repeat (5) cyc(1, 1, 0, 0, 0);
  endtask

  int p0;

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("reset_state", int'(bus.state), 0);
    chk("reset_last", int'(bus.last_sleep_ticks), 0);
    rst = 1'b0;
    // Normal entry with sleep_in held.
    cyc(1, 1, 0, 0, 0);
    chk("entry_drowsy", int'(bus.state), 1);
    repeat (3) cyc(1, 1, 0, 0, 0);
    chk("still_drowsy", int'(bus.state), 1);
    cyc(1, 1, 0, 0, 0);
    chk("entry_asleep", int'(bus.state), 2);
    repeat (7) cyc(1, 1, 0, 0, 0);
    chk("not_deep_yet", int'(bus.deep_sleep), 0);
    cyc(1, 1, 0, 0, 0);
    chk("deep_at_8", int'(bus.deep_sleep), 1);
    chk("no_pulse_yet", int'(bus.restore_pulse), 0);
    cyc(1, 1, 0, 0, 0);
    chk("first_pulse", int'(bus.restore_pulse), 1);
    // Drowsy abort and collapse.
    do_reset();
    repeat (3) cyc(1, 1, 0, 0, 0);
    chk("drowsy_cnt2", int'(bus.state), 1);
    cyc(1, 0, 0, 0, 0);
    chk("drowsy_abort", int'(bus.state), 0);
    cyc(1, 1, 0, 1, 0);
    chk("collapse", int'(bus.state), 2);
    // Wake held from the first asleep tick.
    do_reset();
    fall_asleep();
    repeat (16) cyc(1, 0, 1, 0, 0);
    chk("min_sleep_hold", int'(bus.state), 2);
    cyc(1, 0, 1, 0, 0);
    chk("wake_waking", int'(bus.state), 3);
    chk("wake_last17", int'(bus.last_sleep_ticks), 17);
    cyc(1, 1, 0, 1, 0);
    chk("waking_ignores", int'(bus.state), 3);
    cyc(1, 1, 0, 1, 0);
    chk("wake_awake", int'(bus.state), 0);
    // Urgent wake on tick 3.
    do_reset();
    p0 = pulses;
    fall_asleep();
    repeat (2) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("urgent_waking", int'(bus.state), 3);
    chk("urgent_last3", int'(bus.last_sleep_ticks), 3);
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("urgent_no_pulse", pulses - p0, 0);
    // Reset mid-sleep with last=7 and cnt=10.
    do_reset();
    fall_asleep();
    repeat (6) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 0, 0);
    chk("setup_last7", int'(bus.last_sleep_ticks), 7);
    fall_asleep();
    repeat (10) cyc(1, 1, 0, 0, 0);
    chk("setup_asleep", int'(bus.state), 2);
    rst = 1'b1;
    #1;
    chk("async_state", int'(bus.state), 0);
    chk("async_asleep", int'(bus.is_asleep), 0);
    chk("async_deep", int'(bus.deep_sleep), 0);
    chk("async_pulse", int'(bus.restore_pulse), 0);
    chk("async_last", int'(bus.last_sleep_ticks), 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    // Long sleep with tick every third cycle.
    fall_asleep();
    p0 = pulses;
    for (int i = 0; i < 299 * 3; i++) cyc(i % 3 == 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("long_waking", int'(bus.state), 3);
    chk("long_last255", int'(bus.last_sleep_ticks), 255);
    cyc(0, 0, 0, 0, 0);
    chk("long_pulses", pulses - p0, 292);
    // Random phase.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0);
    end
    cyc(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
